pcie_vc_credit_arbiter: RTL

PCIE_VC_CREDIT_ARBITER -- requirements
Module: pcie_vc_credit_arbiter

---
 rtl/pcie_vc_credit_arbiter_pkg.sv | 18 +
 rtl/pcie_vc_credit_arbiter_credit.sv | 41 ++++
 rtl/pcie_vc_credit_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/pcie_vc_credit_arbiter_pkg.sv
// Shared types for the PCIe two-VC credit arbiter.
// Holds FSM states, VC identifier and the default TLP width.
package pcie_vc_credit_arbiter_pkg;

    localparam int TLP_W_DEF = 224;

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_ARB  = 2'd1,
        S_SEND = 2'd2
    } arb_state_t;

    typedef enum logic {
        VC0 = 1'b0,
        VC1 = 1'b1
    } vc_id_t;

endpackage

// File: rtl/pcie_vc_credit_arbiter_credit.sv
// Per-VC flow-control credit counter.
// Load, +1 on return, -1 on grant, saturating, with nonzero flag.
module pcie_credit_counter #(
    parameter int CRED_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [CRED_W-1:0] load_val_i,
    input  logic              inc_i,
    input  logic              dec_i,
    output logic              nonzero_o
);

    localparam logic [CRED_W-1:0] CNT_MAX = '1;
    localparam logic [CRED_W-1:0] CNT_ONE = CRED_W'(1);

    logic [CRED_W-1:0] cnt_q;
    logic [CRED_W-1:0] cnt_d;

    // Next count: load wins; simultaneous inc and dec cancel out.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (inc_i && !dec_i) begin
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
        end else if (dec_i && !inc_i) begin
            if (cnt_q != '0) cnt_d = cnt_q - CNT_ONE;
        end
    end

    // Credit register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign nonzero_o = (cnt_q != '0);

endmodule

// File: rtl/pcie_vc_credit_arbiter.sv
// Two-VC credit-gated TLP arbiter with weighted round robin.
// Define PCIE_VC_ARB_STRICT_EN for VC1 strict priority instead.
module pcie_vc_credit_arbiter
    import pcie_vc_credit_arbiter_pkg::*;
#(
    parameter int TLP_W      = TLP_W_DEF,
    parameter int CRED_W     = 8,
    parameter int VC0_WEIGHT = 3,
    parameter int VC1_WEIGHT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vc0_empty_i,
    input  logic [TLP_W-1:0]  vc0_rdata_i,
    output logic              vc0_rden_o,
    input  logic              vc1_empty_i,
    input  logic [TLP_W-1:0]  vc1_rdata_i,
    output logic              vc1_rden_o,
    input  logic              cred_init_valid_i,
    input  logic [CRED_W-1:0] cred_init_vc0_i,
    input  logic [CRED_W-1:0] cred_init_vc1_i,
    input  logic              cred_ret_vc0_i,
    input  logic              cred_ret_vc1_i,
    output logic              tlp_valid_o,
    output logic [TLP_W-1:0]  tlp_o,
    output logic              tlp_vc_o,
    input  logic              tlp_ready_i
);

    arb_state_t        state_q, state_d;
    logic [TLP_W-1:0]  tlp_q, tlp_d;
    vc_id_t            vc_q, vc_d;

    logic nz0, nz1;
    logic elig0, elig1;
    logic grant0, grant1;
    logic arb_en;
    logic cred_load;
    logic ret_en;

    assign arb_en    = (state_q == S_ARB);
    assign cred_load = (state_q == S_INIT) && cred_init_valid_i;
    assign ret_en    = (state_q != S_INIT);
    assign elig0     = !vc0_empty_i && nz0;
    assign elig1     = !vc1_empty_i && nz1;

    pcie_credit_counter #(.CRED_W(CRED_W)) u_cred_vc0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (cred_load),
        .load_val_i (cred_init_vc0_i),
        .inc_i      (cred_ret_vc0_i && ret_en),
        .dec_i      (grant0),
        .nonzero_o  (nz0)
    );

    pcie_credit_counter #(.CRED_W(CRED_W)) u_cred_vc1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (cred_load),
        .load_val_i (cred_init_vc1_i),
        .inc_i      (cred_ret_vc1_i && ret_en),
        .dec_i      (grant1),
        .nonzero_o  (nz1)
    );

`ifdef PCIE_VC_ARB_STRICT_EN
    assign grant1 = arb_en && elig1;
    assign grant0 = arb_en && elig0 && !elig1;
`else
    localparam logic [3:0] W0 = VC0_WEIGHT[3:0];
    localparam logic [3:0] W1 = VC1_WEIGHT[3:0];

    vc_id_t     pref_q, pref_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] cnt_inc;
    logic [3:0] w_pref;
    logic       pref_elig, oth_elig;
    logic       grant_pref, grant_oth;

    assign pref_elig  = (pref_q == VC0) ? elig0 : elig1;
    assign oth_elig   = (pref_q == VC0) ? elig1 : elig0;
    assign grant_pref = arb_en && pref_elig;
    assign grant_oth  = arb_en && !pref_elig && oth_elig;
    assign grant0     = (pref_q == VC0) ? grant_pref : grant_oth;
    assign grant1     = (pref_q == VC1) ? grant_pref : grant_oth;
    assign cnt_inc    = cnt_q + 4'd1;
    assign w_pref     = (pref_q == VC0) ? W0 : W1;

    // Only a preferred-VC grant advances the turn; fallbacks leave it.
    always_comb begin
        pref_d = pref_q;
        cnt_d  = cnt_q;
        if (grant_pref) begin
            if (cnt_inc == w_pref) begin
                pref_d = (pref_q == VC0) ? VC1 : VC0;
                cnt_d  = '0;
            end else begin
                cnt_d  = cnt_inc;
            end
        end
    end

    // WRR turn pointer and run length.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pref_q <= VC0;
            cnt_q  <= '0;
        end else begin
            pref_q <= pref_d;
            cnt_q  <= cnt_d;
        end
    end
`endif

    // FSM next state and TLP capture on grant.
    always_comb begin
        state_d = state_q;
        tlp_d   = tlp_q;
        vc_d    = vc_q;
        unique case (state_q)
            S_INIT: begin
                if (cred_init_valid_i) state_d = S_ARB;
            end
            S_ARB: begin
                if (grant0 || grant1) begin
                    tlp_d   = grant1 ? vc1_rdata_i : vc0_rdata_i;
                    vc_d    = grant1 ? VC1 : VC0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (tlp_ready_i) state_d = S_ARB;
            end
            default: state_d = S_INIT;
        endcase
    end

    // FSM state and held TLP registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_INIT;
            tlp_q   <= '0;
            vc_q    <= VC0;
        end else begin
            state_q <= state_d;
            tlp_q   <= tlp_d;
            vc_q    <= vc_d;
        end
    end

    assign vc0_rden_o  = grant0;
    assign vc1_rden_o  = grant1;
    assign tlp_valid_o = (state_q == S_SEND);
    assign tlp_o       = tlp_q;
    assign tlp_vc_o    = vc_q;

endmodule
